dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache for the 8-bit single-cycle CPU.
- Sits between the CPU data path and data memory. The ALU RESULT is the CPU-side ADDRESS. The cache answers CPU load/store requests and initiates 32-bit block transfers to the slower memory.
- Stalls the CPU through BUSYWAIT on misses.

Parameters:
- NBLOCKS, 8, number of cache lines; index width = log2(NBLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width 2; memory data width 32.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  byte address from ALU RESULT; [7:5] tag, [4:2] index, [1:0] offset.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block read request to memory.
- MEM_WRITE  out  1  block write-back request to memory.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  block being written back; byte 0 is bits [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Storage per line: 32-bit data, 3-bit tag, valid bit, dirty bit.
- HIT = valid[index] & (tag[index] == ADDRESS[7:5]). HIT is combinational.
- Reset (RESET_N low, asynchronous):
  - all valid and dirty bits cleared; data and tag arrays are don't-care;
  - state = IDLE;
  - MEM_READ = 0, MEM_WRITE = 0, BUSYWAIT = 0, READDATA = 8'h00, MEM_ADDRESS = 0, MEM_WRITEDATA = 0.
- Reset mid-miss aborts the transfer immediately. No line is updated.
- WRITE has priority if READ and WRITE are both high. The request is treated as a store.
- BUSYWAIT = (READ | WRITE) & ~(state == IDLE & HIT). BUSYWAIT is combinational, so a miss stalls the CPU in the same cycle as the request.
- Read hit: READDATA = selected byte, combinationally, zero extra latency. READDATA = 8'h00 when there is no read hit.
- Write hit: at the next posedge, the selected byte is written and dirty = 1. No stall.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, on a miss:
  - if the line is valid and dirty, go to WRITEBACK;
  - otherwise go to FETCH.
- WRITEBACK:
  - MEM_WRITE = 1;
  - MEM_ADDRESS = {stored tag, index};
  - MEM_WRITEDATA = line data.
- FETCH:
  - MEM_READ = 1;
  - MEM_ADDRESS = {ADDRESS[7:5], index}.
- Memory handshake:
  - The request and address/data stay stable until completion.
  - Completion is the first posedge at which MEM_BUSYWAIT is sampled low after it was sampled high during this request.
  - On completion, WRITEBACK goes to FETCH and FETCH goes to UPDATE.
  - MEM_READ and MEM_WRITE drop in the cycle after completion. They are never high simultaneously.
- UPDATE (one cycle):
  - line data = MEM_READDATA;
  - tag = ADDRESS[7:5], valid = 1, dirty = 0;
  - next state IDLE.
- After UPDATE, HIT re-evaluates. A pending store then completes as a write hit on the following posedge and sets dirty.
- Miss latency, clean line: 1 request cycle + memory cycles + 1 UPDATE + 1 IDLE-hit cycle.
- Request deasserted mid-miss: the transfer and UPDATE still complete, then the FSM returns to IDLE.
- Address must stay stable while BUSYWAIT is high. A change during a miss is a protocol violation and is flagged by a bench assertion.

Test Plan:
- Reset, then READ addr 8'h25 with memory returning 32'hDDCCBBAA → BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h09. After UPDATE, READDATA=8'hBB and BUSYWAIT=0. A second READ of 8'h25 hits with 0 stall cycles.
- WRITE 8'h5A to 8'h24 after that fill → no stall; line 1 byte 0 becomes 8'h5A, dirty=1.
- READ 8'hA4 (same index, tag 5) with line 1 dirty → MEM_WRITE=1, MEM_ADDRESS=6'h09, MEM_WRITEDATA=32'hDDCCBB5A. Then MEM_READ=1 with MEM_ADDRESS=6'h29. Then UPDATE, and dirty=0.
- READ and WRITE both high on a hit, WRITEDATA=8'h11, addr 8'hA5 → store performed; READDATA not required.
- RESET_N pulsed low during FETCH → MEM_READ drops asynchronously, all valid=0, and a re-read of the same address misses.
- Write miss to an invalid line at 8'h1F with WRITEDATA=8'h77 → fetch, update, then byte 3 = 8'h77, dirty=1, BUSYWAIT drops after the write cycle.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between an 8-bit CPU
// and a 32-bit block memory; stalls the CPU via BUSYWAIT on misses.
module dcache_controller #(
  parameter int NBLOCKS     = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                                  CLK,
  input  logic                                  RESET_N,
  input  logic                                  READ,
  input  logic                                  WRITE,
  input  logic [7:0]                            ADDRESS,
  input  logic [7:0]                            WRITEDATA,
  output logic [7:0]                            READDATA,
  output logic                                  BUSYWAIT,
  output logic                                  MEM_READ,
  output logic                                  MEM_WRITE,
  output logic [7-$clog2(BLOCK_BYTES):0]        MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0]              MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0]              MEM_READDATA,
  input  logic                                  MEM_BUSYWAIT
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NBLOCKS);
  localparam int TAG_W = 8 - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t             state;
  logic [NBLOCKS-1:0] valid;
  logic [NBLOCKS-1:0] dirty;
  logic [LINE_W-1:0]  data_arr [NBLOCKS];
  logic [TAG_W-1:0]   tag_arr  [NBLOCKS];
  logic               seen_busy;
  logic [TAG_W-1:0]   miss_tag;
  logic [IDX_W-1:0]   miss_idx;

  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic               hit;
  logic               store_hit;

  assign tag       = ADDRESS[7 -: TAG_W];
  assign idx       = ADDRESS[OFF_W +: IDX_W];
  assign off       = ADDRESS[OFF_W-1:0];
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign store_hit = (state == IDLE) && WRITE && hit;

  assign BUSYWAIT = (READ | WRITE) & ~((state == IDLE) & hit);
  assign READDATA = (READ && hit) ? data_arr[idx][{off, 3'b000} +: 8] : 8'h00;

  // Line storage carries no reset; the valid bits alone decide what is live.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data_arr[miss_idx] <= MEM_READDATA;
      tag_arr[miss_idx]  <= miss_tag;
    end else if (store_hit) begin
      data_arr[idx][{off, 3'b000} +: 8] <= WRITEDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      seen_busy     <= 1'b0;
      miss_tag      <= '0;
      miss_idx      <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty[idx] <= 1'b1;
          end else if ((READ || WRITE) && !hit) begin
            // The miss address is latched so the fill is unaffected if the
            // CPU withdraws its request mid-miss.
            miss_tag  <= tag;
            miss_idx  <= idx;
            seen_busy <= 1'b0;
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_arr[idx], idx};
              MEM_WRITEDATA <= data_arr[idx];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (MEM_BUSYWAIT) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            seen_busy   <= 1'b0;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {miss_tag, miss_idx};
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (MEM_BUSYWAIT) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            seen_busy <= 1'b0;
            MEM_READ  <= 1'b0;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random accesses,
// checked against a line-level cache model and a behavioural block memory.
module tb_dcache_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busy;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .CLK(clk), .RESET_N(rst_n), .READ(read), .WRITE(write),
    .ADDRESS(address), .WRITEDATA(writedata), .READDATA(readdata),
    .BUSYWAIT(busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata),
    .MEM_READDATA(mem_rdata), .MEM_BUSYWAIT(mem_busy)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 9) return 32'hDDCCBBAA;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Block memory: busy for a random few cycles per request, then completes.
  logic [31:0] mem_store [64];
  logic [63:0] written = '0;
  int          mphase, mcnt;
  logic        mop_wr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mphase <= 0; mcnt <= 0; mem_busy <= 1'b0; mop_wr <= 1'b0;
    end else begin
      case (mphase)
        0: if (mem_read || mem_write) begin
             mem_busy <= 1'b1;
             mcnt     <= $urandom_range(1, 3);
             mop_wr   <= mem_write;
             mphase   <= 1;
           end
        1: if (mcnt > 1) mcnt <= mcnt - 1;
           else begin
             mem_busy <= 1'b0;
             mphase   <= 2;
             if (mop_wr) begin
               mem_store[mem_address] <= mem_writedata;
               written[mem_address]   <= 1'b1;
             end else begin
               mem_rdata <= written[mem_address] ? mem_store[mem_address]
                                                 : init_val(int'(mem_address));
             end
           end
        default: mphase <= 0;
      endcase
    end
  end

  // CPU protocol: address must not move while the cache is stalling.
  logic       busy_prev = 1'b0;
  logic [7:0] addr_prev = '0;
  always @(negedge clk) begin
    if (busy_prev && busywait)
      assert (address == addr_prev) else $error("address changed during stall");
    busy_prev <= busywait;
    addr_prev <= address;
  end

  // Reference model: cache lines and the memory image they imply.
  logic [31:0] m_data [8];
  logic [2:0]  m_tag  [8];
  logic [7:0]  m_valid, m_dirty;
  logic [31:0] ref_mem [64];

  logic [7:0]  last_rdata;
  logic [31:0] last_wb_data;
  logic [5:0]  last_wb_addr, last_rd_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    logic [2:0]  idx, tg;
    logic [1:0]  off;
    logic        exp_hit, exp_wb;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [7:0]  exp_rdata;
    int stall, memc;
    logic wb_seen, both;
    idx = a[4:2]; tg = a[7:5]; off = a[1:0];
    exp_hit     = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr = {m_tag[idx], idx};
    exp_wb_data = m_data[idx];
    if (!exp_hit) begin
      if (exp_wb) ref_mem[exp_wb_addr] = m_data[idx];
      m_data[idx]  = ref_mem[{tg, idx}];
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = m_data[idx][8*off +: 8];

    read = rd; write = wr; address = a; writedata = wd;
    stall = 0; memc = 0; wb_seen = 1'b0; both = 1'b0;
    @(negedge clk);
    while (busywait) begin
      stall++;
      if (mem_write) begin
        wb_seen = 1'b1; last_wb_addr = mem_address; last_wb_data = mem_writedata;
      end
      if (mem_read) last_rd_addr = mem_address;
      if (mem_read && mem_write) both = 1'b1;
      if (mem_read || mem_write) memc++;
      if (stall >= 300) begin
        $display("FAIL stall_timeout addr=%0h observed=%0d cycles expected=<300", a, stall);
        $fatal(1, "cache never released the CPU");
      end
      @(negedge clk);
    end
    last_rdata = readdata;
    if (exp_hit) chk("hit_no_stall", stall, 0);
    else begin
      chk("miss_latency", stall, memc + 2);
      chk("writeback_issued", wb_seen, exp_wb);
      if (exp_wb) begin
        chk("wb_addr", last_wb_addr, exp_wb_addr);
        chk("wb_data", last_wb_data, exp_wb_data);
      end
      chk("fetch_addr", last_rd_addr, {tg, idx});
      chk("rd_wr_exclusive", both, 1'b0);
    end
    if (rd && !wr) chk("readdata", last_rdata, exp_rdata);
    if (wr) begin
      m_data[idx][8*off +: 8] = wd;
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    int found;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    m_valid = '0; m_dirty = '0;
    for (int i = 0; i < 8; i++) begin m_data[i] = '0; m_tag[i] = '0; end
    read = 1'b0; write = 1'b0; address = '0; writedata = '0; rst_n = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busywait", busywait, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_readdata", readdata, 8'h00);
    chk("rst_mem_address", mem_address, 6'h00);
    chk("rst_mem_writedata", mem_writedata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold read miss, then a hit on the same byte.
    access(1'b1, 1'b0, 8'h25, 8'h00);
    chk("tp_fill_addr", last_rd_addr, 6'h09);
    chk("tp_read_bb", last_rdata, 8'hBB);
    access(1'b1, 1'b0, 8'h25, 8'h00);
    access(1'b0, 1'b1, 8'h24, 8'h5A);
    access(1'b1, 1'b0, 8'h24, 8'h00);
    chk("tp_store_5a", last_rdata, 8'h5A);

    // Conflict on dirty line 1 forces a write-back before the fetch.
    access(1'b1, 1'b0, 8'hA4, 8'h00);
    chk("tp_wb_addr", last_wb_addr, 6'h09);
    chk("tp_wb_data", last_wb_data, 32'hDDCCBB5A);
    chk("tp_fetch_addr", last_rd_addr, 6'h29);

    access(1'b1, 1'b1, 8'hA5, 8'h11);
    access(1'b1, 1'b0, 8'hA5, 8'h00);
    chk("tp_rw_store", last_rdata, 8'h11);

    // Reset while a fetch is outstanding.
    read = 1'b1; address = 8'h48;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (mem_read) found = 1;
    end
    chk("rst_fetch_reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_read", mem_read, 1'b0);
    chk("rst_async_mem_address", mem_address, 6'h00);
    chk("rst_async_busywait", busywait, 1'b1);
    read = 1'b0;
    #1 chk("rst_idle_busywait", busywait, 1'b0);
    m_valid = '0; m_dirty = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 8'h48, 8'h00);
    access(1'b1, 1'b0, 8'h25, 8'h00);
    chk("tp_reset_lost_store", last_rdata, 8'hBB);

    // Write miss on an invalid line, then evict it to expose the stored byte.
    access(1'b0, 1'b1, 8'h1F, 8'h77);
    access(1'b1, 1'b0, 8'h1F, 8'h00);
    chk("tp_write_miss", last_rdata, 8'h77);
    access(1'b1, 1'b0, 8'hFF, 8'h00);
    chk("tp_evict_byte3", last_wb_data[31:24], 8'h77);

    for (int n = 0; n < 250; n++) begin
      logic [7:0] a;
      int op;
      a  = {3'($urandom_range(0, 7)), 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      access(op != 1, op == 1 || op == 2, a, 8'($urandom));
    end

    // Flush every dirty line, then compare the whole memory image.
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && m_dirty[i])
        access(1'b1, 1'b0, {m_tag[i] + 3'd1, 3'(i), 2'b00}, 8'h00);
    for (int i = 0; i < 64; i++)
      chk("mem_image", written[i] ? mem_store[i] : init_val(i), ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
